// File: rtl/uart_rx_fifo_if.sv
// Bundle of the receiver handshake, CPU read/flush controls and FIFO status.
// The master side drives receiver and CPU inputs; the slave side is the FIFO.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH = 4
);
    logic                     rx_valid_in;
    logic [7:0]               rx_data_in;
    logic                     rx_read_out;
    logic                     read_in;
    logic                     flush_in;
    logic [7:0]               data_out;
    logic                     valid_out;
    logic                     full_out;
    logic [$clog2(DEPTH):0]   count_out;
    logic                     irq_level;

    modport master (
        output rx_valid_in, rx_data_in, read_in, flush_in,
        input  rx_read_out, data_out, valid_out, full_out, count_out, irq_level
    );

    modport slave (
        input  rx_valid_in, rx_data_in, read_in, flush_in,
        output rx_read_out, data_out, valid_out, full_out, count_out, irq_level
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the UART receiver and the CPU data register, with a
// level interrupt once THRESH or more bytes are waiting.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned THRESH = 1
) (
    input logic             clk,
    input logic             rstn,
    uart_rx_fifo_if.slave   bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic [CW-1:0] count;
    logic          rx_read;
    logic          full;
    logic          valid;
    logic          push;
    logic          pop;

    assign full  = (count == CW'(DEPTH));
    assign valid = (count != '0);

    // rx_read blocks a second capture while the receiver is still lowering valid.
    assign push = bus.rx_valid_in && !rx_read && !full && !bus.flush_in;
    assign pop  = bus.read_in && valid && !bus.flush_in;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rp      <= '0;
            wp      <= '0;
            count   <= '0;
            rx_read <= 1'b0;
        end else begin
            rx_read <= push;
            if (bus.flush_in) begin
                rp    <= '0;
                wp    <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    wp <= wp + 1'b1;
                end
                if (pop) begin
                    rp <= rp + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Storage is not reset or cleared by flush; only the pointers matter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= bus.rx_data_in;
        end
    end

    assign bus.rx_read_out = rx_read;
    assign bus.data_out    = valid ? mem[rp] : 8'hFF;
    assign bus.valid_out   = valid;
    assign bus.full_out    = full;
    assign bus.count_out   = count;
    assign bus.irq_level   = (count >= CW'(THRESH));
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo against a queue-based model
// of the FIFO and a simple receiver that drops valid after seeing the ack.
module tb_uart_rx_fifo;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned THRESH = 1;

    logic clk;
    logic rstn;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors;
    int         checks;
    int         acks;
    bit         m_ack;
    bit         rand_gap;
    logic [7:0] mq[$];
    logic [7:0] src[$];
    logic [7:0] popped[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs all outputs as {ack, valid, full, irq, count[15:8], data[7:0]}.
    task automatic check_all(input string tag);
        logic [31:0] obs;
        logic [31:0] exp;
        int n;
        n = mq.size();
        obs = '0;
        exp = '0;
        obs[7:0]  = bus.data_out;
        obs[15:8] = 8'(bus.count_out);
        obs[16]   = bus.irq_level;
        obs[17]   = bus.full_out;
        obs[18]   = bus.valid_out;
        obs[19]   = bus.rx_read_out;
        exp[7:0]  = (n > 0) ? mq[0] : 8'hFF;
        exp[15:8] = 8'(n);
        exp[16]   = (n >= THRESH);
        exp[17]   = (n == DEPTH);
        exp[18]   = (n > 0);
        exp[19]   = m_ack;
        chk(tag, obs, exp);
    endtask

    task automatic tick();
        bit push;
        bit pop;
        bit ack_before;
        int n;
        n          = mq.size();
        push       = bus.rx_valid_in && !m_ack && (n < DEPTH) && !bus.flush_in;
        pop        = bus.read_in && (n > 0) && !bus.flush_in;
        ack_before = bus.rx_read_out;
        @(posedge clk);
        #1;
        if (bus.flush_in) begin
            mq.delete();
        end else begin
            if (pop) popped.push_back(mq.pop_front());
            if (push) mq.push_back(bus.rx_data_in);
        end
        m_ack = push;
        if (bus.rx_read_out) acks++;
        check_all("cycle");
        // Receiver: drop the byte one cycle after the ack, then offer the next.
        if (ack_before) bus.rx_valid_in = 1'b0;
        if (!bus.rx_valid_in && src.size() > 0 && (!rand_gap || $urandom_range(0, 2) == 0)) begin
            bus.rx_data_in  = src.pop_front();
            bus.rx_valid_in = 1'b1;
        end
    endtask

    initial begin
        int k;
        int a0;
        logic [7:0] exp_seq[4];
        errors = 0;
        checks = 0;
        acks = 0;
        m_ack = 1'b0;
        rand_gap = 1'b0;
        rstn = 1'b0;
        bus.rx_valid_in = 1'b0;
        bus.rx_data_in = 8'h00;
        bus.read_in = 1'b0;
        bus.flush_in = 1'b0;

        // Reset state
        #12;
        check_all("reset");
        #10 rstn = 1'b1;

        // Single byte
        src.push_back(8'h41);
        acks = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("single_acks", acks, 1);
        chk("single_count", 32'(bus.count_out), 1);
        chk("single_data", bus.data_out, 8'h41);
        chk("single_irq", bus.irq_level, 1);
        bus.read_in = 1'b1;
        chk("single_cpu_sample", bus.data_out, 8'h41);
        tick();
        bus.read_in = 1'b0;
        chk("single_empty_count", 32'(bus.count_out), 0);
        chk("single_empty_data", bus.data_out, 8'hFF);

        // Fill and back-pressure
        for (int i = 0; i < 5; i++) src.push_back(8'(8'h10 + i));
        k = 0;
        while (mq.size() < DEPTH && k < 20) begin tick(); k++; end
        chk("fill_reached", bus.full_out, 1);
        a0 = acks;
        for (int i = 0; i < 10; i++) tick();
        chk("fill_full", bus.full_out, 1);
        chk("fill_no_ack", acks, a0);
        bus.read_in = 1'b1;
        chk("fill_head", bus.data_out, 8'h10);
        tick();
        bus.read_in = 1'b0;
        a0 = acks;
        tick();
        tick();
        chk("fill_recapture", acks, a0 + 1);
        exp_seq = '{8'h11, 8'h12, 8'h13, 8'h14};
        bus.read_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fill_pop", bus.data_out, exp_seq[i]);
            tick();
        end
        bus.read_in = 1'b0;
        chk("fill_drained", 32'(bus.count_out), 0);

        // Wrap-around with interleaved push/pop
        popped.delete();
        for (int i = 0; i < 10; i++) src.push_back(8'(i));
        for (int i = 0; i < 40; i++) begin
            bus.read_in = (mq.size() >= 2) ||
                          (mq.size() == 1 && src.size() == 0 && !bus.rx_valid_in);
            tick();
        end
        bus.read_in = 1'b0;
        chk("wrap_len", popped.size(), 10);
        for (int i = 0; i < 10 && i < popped.size(); i++) chk("wrap_data", popped[i], 8'(i));

        // Simultaneous push and pop at DEPTH-1
        for (int i = 0; i < 3; i++) src.push_back(8'(8'h20 + i));
        k = 0;
        while ((mq.size() < 3 || bus.rx_valid_in) && k < 20) begin tick(); k++; end
        chk("sim_prefill", 32'(bus.count_out), 3);
        src.push_back(8'h23);
        k = 0;
        while (!(bus.rx_valid_in && !bus.rx_read_out) && k < 10) begin tick(); k++; end
        bus.read_in = 1'b1;
        chk("sim_head_before", bus.data_out, 8'h20);
        tick();
        bus.read_in = 1'b0;
        chk("sim_count", 32'(bus.count_out), 3);
        chk("sim_not_full", bus.full_out, 0);
        chk("sim_head_after", bus.data_out, 8'h21);

        // Flush overrides push and pop
        src.push_back(8'h30);
        k = 0;
        while (!(bus.rx_valid_in && !bus.rx_read_out) && k < 10) begin tick(); k++; end
        bus.read_in = 1'b1;
        bus.flush_in = 1'b1;
        tick();
        bus.read_in = 1'b0;
        bus.flush_in = 1'b0;
        chk("flush_count", 32'(bus.count_out), 0);
        chk("flush_no_ack", bus.rx_read_out, 0);
        k = 0;
        while (mq.size() == 0 && k < 10) begin tick(); k++; end
        chk("flush_recapture", bus.data_out, 8'h30);
        tick();
        bus.read_in = 1'b1;
        tick();
        bus.read_in = 1'b0;

        // Randomized traffic
        rand_gap = 1'b1;
        for (int i = 0; i < 60; i++) src.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 300; i++) begin
            bus.read_in  = ($urandom_range(0, 9) < 4);
            bus.flush_in = ($urandom_range(0, 49) == 0);
            tick();
        end
        bus.read_in = 1'b0;
        bus.flush_in = 1'b0;

        // Async reset mid-burst
        rand_gap = 1'b0;
        for (int i = 0; i < 6; i++) src.push_back(8'(8'hA0 + i));
        for (int i = 0; i < 5; i++) tick();
        #3 rstn = 1'b0;
        #1;
        chk("areset_outputs",
            {12'h0, bus.rx_read_out, bus.valid_out, bus.full_out, bus.irq_level,
             8'(bus.count_out), bus.data_out},
            32'h0000_00FF);
        mq.delete();
        m_ack = 1'b0;
        #1 rstn = 1'b1;
        k = 0;
        while (mq.size() == 0 && k < 10) begin tick(); k++; end
        chk("areset_recapture", 32'(bus.count_out), 1);
        for (int i = 0; i < 3; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
